data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Synchronous, byte-addressable data memory with a valid/ready request port and a registered response.
//  Supports RISC-V load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW).
//  Successor to the combinational data memory: clocked, parametrised depth, misaligned split access,
//  bounds/illegal-op faults. Sits between the CPU MEM stage and backing RAM.
// PARAMETERS
//  DEPTH_BYTES      2048  memory size in bytes; power of 2, >= 8
//  ADDR_W           32    width of Address; only low $clog2(DEPTH_BYTES) bits index RAM
//  ALLOW_MISALIGNED 1     1: word-crossing accesses split into 2 RAM cycles; 0: such accesses fault
// PORTS
//  clk       in   1       single clock, rising edge
//  rst_n     in   1       reset, synchronous, active-low
//  ReqValid  in   1       request present
//  ReqReady  out  1       block can accept; transfer when ReqValid && ReqReady
//  Address   in   ADDR_W  byte address
//  DataWr    in   32      store data, LSB-aligned (byte in [7:0], half in [15:0])
//  DMWr      in   1       1 = store, 0 = load
//  DMCtrl    in   3       000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
//  RspValid  out  1       one-cycle pulse: response for accepted request
//  DataRd    out  32      load result (sign/zero-extended); 0 for stores and faults
//  Fault     out  1       qualified by RspValid: out-of-range, illegal DMCtrl, or disallowed misalign
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    - State goes to IDLE.
//    - RspValid=0, DataRd=0, Fault=0; ReqReady=1 from the first cycle after reset.
//    - RAM contents are not reset.
//  - FSM: IDLE -> {RESP | SPLIT}; SPLIT -> RESP; RESP -> IDLE. ReqReady=1 only in IDLE.
//  - Size: B/BU=1, H/HU=2, W=4 bytes; off = Address[1:0]. Split when off+size > 4.
//  - Fault is detected at accept when any of these holds:
//    - Address+size-1 >= DEPTH_BYTES (computed in ADDR_W+1 bits, no wrap);
//    - DMCtrl illegal (incl. 011 with DMWr=1);
//    - split and ALLOW_MISALIGNED=0.
//    On fault: no RAM access, next state RESP, Fault=1, DataRd=0.
//  - Aligned (non-split) access:
//    - Cycle 0: accept, RAM word access.
//    - Cycle 1: RESP with RspValid=1.
//    - Latency 1, throughput 1 request / 2 cycles.
//  - Split access:
//    - Cycle 0: lower word.
//    - Cycle 1 (SPLIT): upper word; lower read data captured into hold register.
//    - Cycle 2: RESP. Latency 2.
//  - Stores: byte-enable write in the access cycle(s), no read-modify-write; untouched bytes are preserved.
//  - Loads: little-endian assembly from up to 2 words, then sign-extend (000/001) or zero-extend (100/101).
//  - DataRd/Fault are registered and hold their last value between pulses; meaningful only when RspValid=1.
//  - Inputs are sampled only at accept; changes to them while busy are ignored.
//  - Reset mid-operation: the FSM aborts to IDLE and no RspValid is issued.
//    A split store interrupted after cycle 0 leaves the lower bytes written and the upper bytes unchanged.
//  - ReqValid without ReqReady: no effect; the request must be held by the master.
// STRUCTURE
//  - Package dm_pkg:
//    - dm_ctrl_e enum (DM_B=3'b000, DM_H, DM_W, DM_BU=3'b100, DM_HU);
//    - dm_state_e (IDLE, SPLIT, RESP);
//    - function size_of(dm_ctrl_e).
//  - Sub-module dm_word_ram:
//    - DEPTH_BYTES/4 x 32 array;
//    - one port, 4-bit byte-enable write, synchronous read (data valid next cycle).
//  - Top holds the FSM, lane shift/byte-enable generation, hold register and extension logic.
// TESTING
//  1. Reset, then SW 0xDEADBEEF @0x10 and LW @0x10.
//     -> RspValid 1 cycle after each accept; DataRd=0xDEADBEEF, Fault=0.
//  2. Signed vs unsigned byte load from that word:
//     - LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE;
//     - LH @0x12 -> 0xFFFFDEAD; LHU @0x12 -> 0x0000DEAD.
//  3. Split word access:
//     - SW 0x11223344 @0x0E -> response 2 cycles after accept;
//     - then LW @0x0C -> 0x3344xxxx (upper half=0x3344) and LW @0x10 -> 0xXXXX1122 (low half=0x1122);
//     - LW @0x0E -> 0x11223344.
//  4. Faults:
//     - LW @DEPTH_BYTES-2 -> Fault=1, DataRd=0;
//     - DMCtrl=3'b111 -> Fault=1;
//     - with ALLOW_MISALIGNED=0, LH @0x03 -> Fault=1 and memory unchanged.
//  5. Handshake:
//     - ReqValid held high continuously -> ReqReady=0 in RESP/SPLIT;
//     - exactly one RspValid per accept; changing Address while busy has no effect.
//  6. Reset mid-op:
//     - assert rst_n=0 in SPLIT of SW @0x0E;
//     - no RspValid; ReqReady=1 after reset; bytes 0x0E-0x0F written, 0x10-0x11 unchanged.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and helpers for the clocked data memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_pkg;

  // Load/store width encodings as presented on DMCtrl
  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    RESP  = 2'd2
  } dm_state_e;

  // Request attributes kept for the whole transaction after accept
  typedef struct packed {
    logic       wr;
    logic [2:0] ctrl;
    logic [1:0] off;
    logic       split;
    logic       fault;
  } dm_req_t;

  // Access size in bytes; 0 marks an encoding with no defined width
  function automatic logic [2:0] size_of(input dm_ctrl_e c);
    case (c)
      DM_B, DM_BU: size_of = 3'd1;
      DM_H, DM_HU: size_of = 3'd2;
      DM_W:        size_of = 3'd4;
      default:     size_of = 3'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] c);
    case (c)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_legal = 1'b1;
      default:                                 is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Single-port word RAM with per-byte write enables.
// Latency: read data registered, valid the cycle after an enabled access.
// Backpressure: none; accepts an access every cycle it is enabled.
module dm_word_ram #(
  parameter int DEPTH_BYTES = 2048,
  parameter int WAW         = $clog2(DEPTH_BYTES / 4)
) (
  input  logic           clk,
  input  logic           en,
  input  logic           we,
  input  logic [3:0]     be,
  input  logic [WAW-1:0] addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata
);

  localparam int WORDS = DEPTH_BYTES / 4;

  logic [31:0] mem [WORDS];

  // Byte-lane writes and read-before-write data capture; contents are never reset
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with valid/ready requests, RISC-V load/store widths, split misaligned access.
// Latency: 1 cycle accept-to-response (2 when the access crosses a word boundary); faults respond in 1.
// Backpressure: ReqReady only in IDLE; a request offered while busy is held by the master until accepted.
import dm_pkg::*;

module data_memory_ctrl #(
  parameter int DEPTH_BYTES      = 2048,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataWr,
  input  logic              DMWr,
  input  logic [2:0]        DMCtrl,
  output logic              RspValid,
  output logic [31:0]       DataRd,
  output logic              Fault
);

  localparam int AW  = $clog2(DEPTH_BYTES);
  localparam int WAW = AW - 2;
  localparam int EW  = ADDR_W + 1;

  dm_state_e state_q, state_d;
  dm_req_t   req_q;

  // request decode (valid only in the accept cycle)
  logic [2:0]     size_c;
  logic [1:0]     off_c;
  logic [3:0]     span_c;
  logic           split_c;
  logic           oob_c;
  logic           illegal_c;
  logic           fault_c;
  logic [EW-1:0]  end_addr_c;
  logic [3:0]     mask_c;
  logic [7:0]     be8_c;
  logic [63:0]    wdata64_c;
  logic [WAW-1:0] lo_addr_c;
  logic           accept;

  // upper-word access parameters carried into SPLIT
  logic [WAW-1:0] hi_addr_q;
  logic [3:0]     hi_be_q;
  logic [31:0]    hi_data_q;
  logic [31:0]    hold_q;

  // RAM port
  logic           ram_en;
  logic           ram_we;
  logic [3:0]     ram_be;
  logic [WAW-1:0] ram_addr;
  logic [31:0]    ram_wdata;
  logic [31:0]    ram_rdata;

  // response path
  logic [63:0]    cat_c;
  logic [31:0]    lane_c;
  logic [31:0]    ext_c;
  logic [31:0]    rd_c;
  logic [31:0]    dr_q;

  assign ReqReady = (state_q == IDLE);
  // An edge with rst_n low must never commit a transfer
  assign accept   = ReqValid && ReqReady && rst_n;

  // Decode size, alignment, range and legality of the offered request
  always_comb begin
    size_c     = size_of(dm_ctrl_e'(DMCtrl));
    off_c      = Address[1:0];
    span_c     = {2'b00, off_c} + {1'b0, size_c};
    split_c    = (span_c > 4'd4);
    // end address in one extra bit so the top of the address space cannot wrap to "in range"
    end_addr_c = {1'b0, Address} + EW'(size_c) - EW'(1);
    oob_c      = (end_addr_c >= EW'(DEPTH_BYTES));
    illegal_c  = !is_legal(DMCtrl);
    fault_c    = oob_c || illegal_c || (split_c && (ALLOW_MISALIGNED == 0));
    case (size_c)
      3'd1:    mask_c = 4'b0001;
      3'd2:    mask_c = 4'b0011;
      3'd4:    mask_c = 4'b1111;
      default: mask_c = 4'b0000;
    endcase
    // 8 byte lanes span the addressed word and the next one
    be8_c      = {4'b0000, mask_c} << off_c;
    wdata64_c  = {32'd0, DataWr} << {off_c, 3'b000};
    lo_addr_c  = Address[AW-1:2];
  end

  // Next-state and RAM port steering; the RAM is only touched for non-faulting requests
  always_comb begin
    state_d   = state_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = lo_addr_c;
    ram_wdata = wdata64_c[31:0];
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault_c) begin
            state_d = RESP;
          end else begin
            ram_en  = 1'b1;
            ram_we  = DMWr;
            ram_be  = be8_c[3:0];
            state_d = split_c ? SPLIT : RESP;
          end
        end
      end
      SPLIT: begin
        ram_en    = rst_n;
        ram_we    = req_q.wr;
        ram_be    = hi_be_q;
        ram_addr  = hi_addr_q;
        ram_wdata = hi_data_q;
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight without a response
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture request attributes at accept, lower read word during SPLIT, load result during RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= '0;
      hi_addr_q <= '0;
      hi_be_q   <= '0;
      hi_data_q <= '0;
      hold_q    <= '0;
      dr_q      <= '0;
    end else begin
      if (accept) begin
        req_q.wr    <= DMWr;
        req_q.ctrl  <= DMCtrl;
        req_q.off   <= off_c;
        req_q.split <= split_c && !fault_c;
        req_q.fault <= fault_c;
        hi_addr_q   <= lo_addr_c + WAW'(1);
        hi_be_q     <= be8_c[7:4];
        hi_data_q   <= wdata64_c[63:32];
      end
      if (state_q == SPLIT) hold_q <= ram_rdata;
      if (state_q == RESP)  dr_q   <= rd_c;
    end
  end

  dm_word_ram #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .WAW         (WAW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Little-endian lane assembly and sign/zero extension of the load result
  always_comb begin
    cat_c  = req_q.split ? {ram_rdata, hold_q} : {32'd0, ram_rdata};
    lane_c = cat_c[{req_q.off, 3'b000} +: 32];
    case (req_q.ctrl)
      3'b000:  ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b001:  ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b010:  ext_c = lane_c;
      3'b100:  ext_c = {24'd0, lane_c[7:0]};
      3'b101:  ext_c = {16'd0, lane_c[15:0]};
      default: ext_c = 32'd0;
    endcase
    rd_c = (req_q.wr || req_q.fault) ? 32'd0 : ext_c;
  end

  // RAM read data is only current in RESP; otherwise present the held result
  assign RspValid = (state_q == RESP);
  assign DataRd   = (state_q == RESP) ? rd_c : dr_q;
  assign Fault    = req_q.fault;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // main instance: 2048 bytes, misaligned split allowed
  logic        ReqValid, ReqReady, DMWr, RspValid, Fault;
  logic [31:0] Address, DataWr, DataRd;
  logic [2:0]  DMCtrl;

  // second instance: 256 bytes, misaligned access faults
  logic        rv0, rr0, wr0, sv0, f0;
  logic [31:0] a0, dw0, dr0;
  logic [2:0]  c0;

  typedef struct {
    logic [31:0] d;
    logic        f;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  data_memory_ctrl #(.DEPTH_BYTES(2048), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady), .Address(Address),
    .DataWr(DataWr), .DMWr(DMWr), .DMCtrl(DMCtrl), .RspValid(RspValid), .DataRd(DataRd), .Fault(Fault)
  );

  data_memory_ctrl #(.DEPTH_BYTES(256), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ReqValid(rv0), .ReqReady(rr0), .Address(a0),
    .DataWr(dw0), .DMWr(wr0), .DMCtrl(c0), .RspValid(sv0), .DataRd(dr0), .Fault(f0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every response must match the oldest outstanding expectation, in cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && RspValid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {31'd0, RspValid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", DataRd, e.d);
        check("rsp_fault", {31'd0, Fault}, {31'd0, e.f});
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // offer one request to the main instance; hold keeps ReqValid high with junk after accept
  task automatic req(input logic [31:0] addr, input logic [31:0] wd, input logic wr,
                     input logic [2:0] ctl, input logic [31:0] ed, input logic ef,
                     input int lat, input bit hold);
    int n;
    exp_t e;
    @(negedge clk);
    Address = addr; DataWr = wd; DMWr = wr; DMCtrl = ctl; ReqValid = 1'b1;
    n = 0;
    while (ReqReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", {31'd0, ReqReady}, 32'd1);
    e.d = ed; e.f = ef; e.cyc = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (hold) begin
      Address = 32'h7FC; DataWr = 32'hFFFF_FFFF; DMWr = 1'b1; DMCtrl = 3'b010;
      check("busy_not_ready", {31'd0, ReqReady}, 32'd0);
    end else begin
      ReqValid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic req0(input logic [31:0] addr, input logic [31:0] wd, input logic wr,
                      input logic [2:0] ctl, input logic [31:0] ed, input logic ef);
    int n;
    @(negedge clk);
    a0 = addr; dw0 = wd; wr0 = wr; c0 = ctl; rv0 = 1'b1;
    n = 0;
    while (rr0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    rv0 = 1'b0;
    @(negedge clk);
    check("rsp0_valid", {31'd0, sv0}, 32'd1);
    check("rsp0_data", dr0, ed);
    check("rsp0_fault", {31'd0, f0}, {31'd0, ef});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ReqValid = 1'b0; Address = '0; DataWr = '0; DMWr = 1'b0; DMCtrl = 3'b010;
    rv0 = 1'b0; a0 = '0; dw0 = '0; wr0 = 1'b0; c0 = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rspvalid", {31'd0, RspValid}, 32'd0);
    check("rst_datard", DataRd, 32'd0);
    check("rst_fault", {31'd0, Fault}, 32'd0);
    check("rst_ready", {31'd0, ReqReady}, 32'd1);
    check("rst0_rspvalid", {31'd0, sv0}, 32'd0);
    rst_n = 1'b1;

    // aligned store then load
    req(32'h10, 32'hDEAD_BEEF, 1'b1, 3'b010, 32'h0, 1'b0, 1, 1'b0);
    req(32'h10, 32'h0,         1'b0, 3'b010, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
    // signed and unsigned narrow loads
    req(32'h13, 32'h0, 1'b0, 3'b000, 32'hFFFF_FFDE, 1'b0, 1, 1'b0);
    req(32'h13, 32'h0, 1'b0, 3'b100, 32'h0000_00DE, 1'b0, 1, 1'b0);
    req(32'h12, 32'h0, 1'b0, 3'b001, 32'hFFFF_DEAD, 1'b0, 1, 1'b0);
    req(32'h12, 32'h0, 1'b0, 3'b101, 32'h0000_DEAD, 1'b0, 1, 1'b0);
    req(32'h10, 32'h0, 1'b0, 3'b000, 32'hFFFF_FFEF, 1'b0, 1, 1'b0);
    req(32'h11, 32'h0, 1'b0, 3'b100, 32'h0000_00BE, 1'b0, 1, 1'b0);
    req(32'h10, 32'h0, 1'b0, 3'b001, 32'hFFFF_BEEF, 1'b0, 1, 1'b0);
    drain();

    // split word access across 0x0C/0x10
    req(32'h0C, 32'hCAFE_F00D, 1'b1, 3'b010, 32'h0, 1'b0, 1, 1'b0);
    req(32'h0E, 32'h1122_3344, 1'b1, 3'b010, 32'h0, 1'b0, 2, 1'b0);
    req(32'h0C, 32'h0, 1'b0, 3'b010, 32'h3344_F00D, 1'b0, 1, 1'b0);
    req(32'h10, 32'h0, 1'b0, 3'b010, 32'hDEAD_1122, 1'b0, 1, 1'b0);
    req(32'h0E, 32'h0, 1'b0, 3'b010, 32'h1122_3344, 1'b0, 2, 1'b0);
    req(32'h0F, 32'h0, 1'b0, 3'b001, 32'h0000_2233, 1'b0, 2, 1'b0);
    drain();

    // range boundary and illegal encodings
    req(32'd2046, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1, 1, 1'b0);
    req(32'd2047, 32'h5A, 1'b1, 3'b000, 32'h0, 1'b0, 1, 1'b0);
    req(32'd2047, 32'h0, 1'b0, 3'b000, 32'h0000_005A, 1'b0, 1, 1'b0);
    req(32'd2047, 32'h0, 1'b0, 3'b001, 32'h0, 1'b1, 1, 1'b0);
    req(32'd2044, 32'h0807_0605, 1'b1, 3'b010, 32'h0, 1'b0, 1, 1'b0);
    req(32'd2044, 32'h0, 1'b0, 3'b010, 32'h0807_0605, 1'b0, 1, 1'b0);
    req(32'hFFFF_FFFC, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1, 1, 1'b0);
    req(32'h10, 32'h0, 1'b0, 3'b111, 32'h0, 1'b1, 1, 1'b0);
    req(32'h10, 32'h1234_5678, 1'b1, 3'b011, 32'h0, 1'b1, 1, 1'b0);
    req(32'h10, 32'h0, 1'b0, 3'b010, 32'hDEAD_1122, 1'b0, 1, 1'b0);
    drain();

    // ReqValid held high with junk inputs while busy
    req(32'h0C, 32'h0, 1'b0, 3'b010, 32'h3344_F00D, 1'b0, 1, 1'b1);
    req(32'h0E, 32'h0, 1'b0, 3'b010, 32'h1122_3344, 1'b0, 2, 1'b1);
    req(32'h10, 32'h0, 1'b0, 3'b010, 32'hDEAD_1122, 1'b0, 1, 1'b0);
    drain();
    req(32'h7FC, 32'h0, 1'b0, 3'b010, 32'h0807_0605, 1'b0, 1, 1'b0);
    drain();

    // misaligned faults on the strict instance leave memory intact
    req0(32'h00, 32'hA1B2_C3D4, 1'b1, 3'b010, 32'h0, 1'b0);
    req0(32'h03, 32'h0,         1'b0, 3'b001, 32'h0, 1'b1);
    req0(32'h03, 32'h0000_FFFF, 1'b1, 3'b001, 32'h0, 1'b1);
    req0(32'h00, 32'h0,         1'b0, 3'b010, 32'hA1B2_C3D4, 1'b0);
    req0(32'h02, 32'h0,         1'b0, 3'b001, 32'hFFFF_A1B2, 1'b0);

    // reset in the upper-word cycle of a split store
    req(32'h0C, 32'h0000_0000, 1'b1, 3'b010, 32'h0, 1'b0, 1, 1'b0);
    req(32'h10, 32'h5566_7788, 1'b1, 3'b010, 32'h0, 1'b0, 1, 1'b0);
    drain();
    @(negedge clk);
    Address = 32'h0E; DataWr = 32'hAABB_CCDD; DMWr = 1'b1; DMCtrl = 3'b010; ReqValid = 1'b1;
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_ready", {31'd0, ReqReady}, 32'd1);
    check("midrst_norsp", {31'd0, RspValid}, 32'd0);
    repeat (3) @(negedge clk);
    req(32'h0C, 32'h0, 1'b0, 3'b010, 32'hCCDD_0000, 1'b0, 1, 1'b0);
    req(32'h10, 32'h0, 1'b0, 3'b010, 32'h5566_7788, 1'b0, 1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
